// File: rtl/vga_sync_timer.sv
// vga_sync_timer: free-running VGA raster timing generator.
// Counts pixel clocks into hpos/vpos. It decodes hsync, vsync, display_on and
// the line/frame start markers into registers, so every output is a flop.
// The decode is taken from the next counter values, which keeps each marker
// aligned with the position it describes.
// Optional feature: define VGA_SYNC_CLKEN_EN to add the pix_en advance enable.
// With it, a low pix_en freezes every register, the markers included.
module vga_sync_timer #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic       clk,
  input  logic       reset,
`ifdef VGA_SYNC_CLKEN_EN
  input  logic       pix_en,
`endif
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

  // Compare bounds use 11 bits because a sync window may end exactly at 1024.
  localparam logic [10:0] H_VIS      = 11'(H_DISPLAY);
  localparam logic [10:0] HS_START   = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS      = 11'(V_DISPLAY);
  localparam logic [10:0] VS_START   = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  // Level driven onto hsync/vsync while the sync window is active.
  localparam logic SYNC_ON = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       display_on_q, display_on_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       adv;
  logic       hs_act;
  logic       vs_act;

  // Advance qualifier: every edge, or only the edges the pixel enable selects.
  always_comb begin
`ifdef VGA_SYNC_CLKEN_EN
    adv = pix_en;
`else
    adv = 1'b1;
`endif
  end

  // Next raster position: hpos wraps at the line end and carries into vpos.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (adv) begin
      if (h_q == H_MAX) begin
        h_d = 10'd0;
        if (v_q == V_MAX) begin
          v_d = 10'd0;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Decode from the next position. A stalled cycle sees unchanged counters,
  // so it rebuilds the same decode values, and the markers hold their level.
  always_comb begin
    hs_act        = ({1'b0, h_d} >= HS_START) && ({1'b0, h_d} < HS_END);
    vs_act        = ({1'b0, v_d} >= VS_START) && ({1'b0, v_d} < VS_END);
    hsync_d       = hs_act ? SYNC_ON : ~SYNC_ON;
    vsync_d       = vs_act ? SYNC_ON : ~SYNC_ON;
    display_on_d  = ({1'b0, h_d} < H_VIS) && ({1'b0, v_d} < V_VIS);
    line_start_d  = (h_d == 10'd0);
    frame_start_d = (h_d == 10'd0) && (v_d == 10'd0);
  end

  // State registers. Reset parks the raster on its last position, so the
  // first advancing edge after release lands on (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q           <= H_MAX;
      v_q           <= V_MAX;
      hsync_q       <= ~SYNC_ON;
      vsync_q       <= ~SYNC_ON;
      display_on_q  <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hpos        = h_q;
  assign vpos        = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_timer.sv
// tb_vga_sync_timer: directed bench for vga_sync_timer.
// Instance a uses the default 640x480 timing with active-low sync.
// Instance b uses a small 16x11 raster with active-high sync, so whole frames
// run in a few hundred cycles.
// The small raster has H: 8 visible, porch 2, sync 3, back 3.
// It has V: 6 visible, porch 1, sync 2, back 2.
module tb_vga_sync_timer;

`ifdef VGA_SYNC_CLKEN_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif
  localparam int B_FRAME = 16 * 11;

  logic       clk = 1'b0;
  logic       rst_a;
  logic       rst_b;
`ifdef VGA_SYNC_CLKEN_EN
  logic       pix_en_a;
  logic       pix_en_b;
`endif

  logic       a_hsync, a_vsync, a_display_on, a_line_start, a_frame_start;
  logic [9:0] a_hpos, a_vpos;
  logic       b_hsync, b_vsync, b_display_on, b_line_start, b_frame_start;
  logic [9:0] b_hpos, b_vpos;

  int n_vec = 0;
  int n_err = 0;

  // clock
  always #5 clk = ~clk;

  vga_sync_timer u_dut_a (
    .clk         (clk),
    .reset       (rst_a),
`ifdef VGA_SYNC_CLKEN_EN
    .pix_en      (pix_en_a),
`endif
    .hsync       (a_hsync),
    .vsync       (a_vsync),
    .display_on  (a_display_on),
    .hpos        (a_hpos),
    .vpos        (a_vpos),
    .line_start  (a_line_start),
    .frame_start (a_frame_start)
  );

  vga_sync_timer #(
    .H_DISPLAY (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (3),
    .V_DISPLAY (6),
    .V_FRONT   (1),
    .V_SYNC    (2),
    .V_BACK    (2),
    .SYNC_POL  (1)
  ) u_dut_b (
    .clk         (clk),
    .reset       (rst_b),
`ifdef VGA_SYNC_CLKEN_EN
    .pix_en      (pix_en_b),
`endif
    .hsync       (b_hsync),
    .vsync       (b_vsync),
    .display_on  (b_display_on),
    .hpos        (b_hpos),
    .vpos        (b_vpos),
    .line_start  (b_line_start),
    .frame_start (b_frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one for sampling.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int fs_rises, fs_first, fs_gap, fs_high, ls_high, disp_cnt, vs_cnt, hs_cnt, viol;
  logic fs_prev;
  logic vs_exp, hs_exp, de_exp;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
`ifdef VGA_SYNC_CLKEN_EN
    pix_en_a = 1'b1;
    pix_en_b = 1'b1;
`endif
    step(3);

    // ---- instance a: reset state, default timing
    check("a_rst_hpos", a_hpos, 799);
    check("a_rst_vpos", a_vpos, 524);
    check("a_rst_hsync", a_hsync, 1);
    check("a_rst_vsync", a_vsync, 1);
    check("a_rst_disp", a_display_on, 0);
    check("a_rst_ls", a_line_start, 0);
    check("a_rst_fs", a_frame_start, 0);

    rst_a = 1'b0;
    step(1);
    check("a_first_hpos", a_hpos, 0);
    check("a_first_vpos", a_vpos, 0);
    check("a_first_disp", a_display_on, 1);
    check("a_first_ls", a_line_start, 1);
    check("a_first_fs", a_frame_start, 1);
    check("a_first_hsync", a_hsync, 1);

    // ---- instance a: walk one line
    step(639);
    check("a_h639", a_hpos, 639);
    check("a_h639_disp", a_display_on, 1);
    check("a_h639_ls", a_line_start, 0);
    step(1);
    check("a_h640_disp", a_display_on, 0);
    step(15);
    check("a_h655", a_hpos, 655);
    check("a_h655_hsync", a_hsync, 1);
    step(1);
    check("a_h656_hsync", a_hsync, 0);
    step(95);
    check("a_h751", a_hpos, 751);
    check("a_h751_hsync", a_hsync, 0);
    step(1);
    check("a_h752_hsync", a_hsync, 1);
    step(47);
    check("a_h799", a_hpos, 799);
    check("a_h799_vpos", a_vpos, 0);
    step(1);
    check("a_wrap_hpos", a_hpos, 0);
    check("a_wrap_vpos", a_vpos, 1);
    check("a_wrap_ls", a_line_start, 1);
    check("a_wrap_fs", a_frame_start, 0);
    check("a_wrap_disp", a_display_on, 1);
    check("a_wrap_vsync", a_vsync, 1);

    // ---- instance a: asynchronous reset mid-line
    step(300);
    check("a_mid_hpos", a_hpos, 300);
    rst_a = 1'b1;
    #2;
    check("a_arst_hpos", a_hpos, 799);
    check("a_arst_vpos", a_vpos, 524);
    check("a_arst_hsync", a_hsync, 1);
    check("a_arst_disp", a_display_on, 0);
    check("a_arst_ls", a_line_start, 0);
    step(2);
    check("a_hold_hpos", a_hpos, 799);
    rst_a = 1'b0;
    step(1);
    check("a_rel_hpos", a_hpos, 0);
    check("a_rel_vpos", a_vpos, 0);
    check("a_rel_fs", a_frame_start, 1);

    // ---- instance b: reset state, active-high sync
    check("b_rst_hpos", b_hpos, 15);
    check("b_rst_vpos", b_vpos, 10);
    check("b_rst_hsync", b_hsync, 0);
    check("b_rst_vsync", b_vsync, 0);
    check("b_rst_disp", b_display_on, 0);
    check("b_rst_fs", b_frame_start, 0);

    rst_b = 1'b0;
    step(1);
    check("b_first_hpos", b_hpos, 0);
    check("b_first_vpos", b_vpos, 0);
    check("b_first_disp", b_display_on, 1);
    check("b_first_ls", b_line_start, 1);
    check("b_first_fs", b_frame_start, 1);
    check("b_first_hsync", b_hsync, 0);

    // ---- instance b: two full frames with cycle counting
    fs_rises = 0; fs_first = 0; fs_gap = 0; fs_high = 0; ls_high = 0;
    disp_cnt = 0; vs_cnt = 0; hs_cnt = 0; viol = 0; fs_prev = 1'b0;
    for (int k = 0; k < 2 * B_FRAME * STRIDE; k++) begin
      if (b_frame_start && !fs_prev) begin
        if (fs_rises == 0) fs_first = k;
        if (fs_rises == 1) fs_gap = k - fs_first;
        fs_rises++;
      end
      fs_prev = b_frame_start;
      if (b_frame_start) fs_high++;
      if (b_line_start) ls_high++;
      if (b_display_on) disp_cnt++;
      if (b_vsync) vs_cnt++;
      if (b_hsync) hs_cnt++;
      vs_exp = (b_vpos >= 10'd7) && (b_vpos <= 10'd8);
      hs_exp = (b_hpos >= 10'd10) && (b_hpos <= 10'd12);
      de_exp = (b_hpos < 10'd8) && (b_vpos < 10'd6);
      if (b_vsync !== vs_exp) viol++;
      if (b_hsync !== hs_exp) viol++;
      if (b_display_on !== de_exp) viol++;
`ifdef VGA_SYNC_CLKEN_EN
      pix_en_b = ((k % 2) == 1);
`endif
      step(1);
    end
    check("b_fs_rises", fs_rises, 2);
    check("b_fs_gap", fs_gap, B_FRAME * STRIDE);
    check("b_fs_high", fs_high, 2 * STRIDE);
    check("b_ls_high", ls_high, 22 * STRIDE);
    check("b_disp_cnt", disp_cnt, 96 * STRIDE);
    check("b_vsync_cnt", vs_cnt, 64 * STRIDE);
    check("b_hsync_cnt", hs_cnt, 66 * STRIDE);
    check("b_decode_viol", viol, 0);

    // ---- instance b: asynchronous reset mid-frame at (5,4)
`ifdef VGA_SYNC_CLKEN_EN
    pix_en_b = 1'b1;
`endif
    check("b_wrap_hpos", b_hpos, 0);
    check("b_wrap_vpos", b_vpos, 0);
    step(69);
    check("b_mid_hpos", b_hpos, 5);
    check("b_mid_vpos", b_vpos, 4);
    rst_b = 1'b1;
    #2;
    check("b_arst_hpos", b_hpos, 15);
    check("b_arst_vpos", b_vpos, 10);
    check("b_arst_hsync", b_hsync, 0);
    check("b_arst_vsync", b_vsync, 0);
    check("b_arst_disp", b_display_on, 0);
    rst_b = 1'b0;
    step(1);
    check("b_rel_hpos", b_hpos, 0);
    check("b_rel_vpos", b_vpos, 0);
    check("b_rel_fs", b_frame_start, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
